// File: rtl/l1_strm_ctrl_if.sv
// l1_strm_ctrl_if -- bundle of every handshake channel around the L1 stream
// controller.
//
// Handshake rule for every channel below: a transfer happens on a rising clk
// edge where both valid and ready are 1. A valid that is 1 and not yet
// accepted keeps its payload stable. Two exceptions: i_rd_r may depend on
// i_rd_v because grants are ranked among the valid ports. i_rsp_r and i_rst_r
// are plain status levels driven by the controller.
//
// Channels (named from the controller's point of view):
//   i_rd_v/i_rd_r/i_rd_sid           read requests, one lane per port
//   o_addr_v/o_addr_r/o_addr_sid/ptr registered BRAM addresses per port
//   o_req_v/o_req_r                  line prefetch requests to L2, per stream
//   i_rsp_v/i_rsp_r                  line arrivals from L2, per stream
//   i_rst_v/i_rst_r                  per-stream reset request / done
//
// Modports:
//   master  the controller side
//   slave   the environment side (ports, BRAM, L2, stream-reset source)
interface l1_strm_ctrl_if #(
  parameter int NPORTS = 8,
  parameter int NSTRMS = 64,
  parameter int SID_W  = 6,
  parameter int PTR_W  = 7
);
  logic [NPORTS-1:0]       i_rd_v;
  logic [NPORTS-1:0]       i_rd_r;
  logic [NPORTS*SID_W-1:0] i_rd_sid;
  logic [NPORTS-1:0]       o_addr_v;
  logic [NPORTS-1:0]       o_addr_r;
  logic [NPORTS*SID_W-1:0] o_addr_sid;
  logic [NPORTS*PTR_W-1:0] o_addr_ptr;
  logic [NSTRMS-1:0]       o_req_v;
  logic [NSTRMS-1:0]       o_req_r;
  logic [NSTRMS-1:0]       i_rsp_v;
  logic [NSTRMS-1:0]       i_rsp_r;
  logic [NSTRMS-1:0]       i_rst_v;
  logic [NSTRMS-1:0]       i_rst_r;

  modport master (
    input  i_rd_v, i_rd_sid, o_addr_r, o_req_r, i_rsp_v, i_rst_v,
    output i_rd_r, o_addr_v, o_addr_sid, o_addr_ptr, o_req_v, i_rsp_r, i_rst_r
  );

  modport slave (
    output i_rd_v, i_rd_sid, o_addr_r, o_req_r, i_rsp_v, i_rst_v,
    input  i_rd_r, o_addr_v, o_addr_sid, o_addr_ptr, o_req_v, i_rsp_r, i_rst_r
  );
endinterface

// File: rtl/l1_strm_ctrl.sv
// l1_strm_ctrl -- L1 stream controller.
//
// Each stream has a read pointer. It also counts the lines that are resident
// and the line prefetches still in flight from L2. Every cycle the read ports
// are granted against the data that is available in their stream. Each granted
// port gets a registered BRAM address. The stream keeps up to PF_DEPTH lines
// resident or in flight by issuing line requests to L2.
//
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    l1_strm_ctrl_if.master, which carries all read, address, L2 and
//          stream-reset channels
module l1_strm_ctrl #(
  parameter int NPORTS   = 8,
  parameter int NSTRMS   = 64,
  parameter int NCL      = 16,
  parameter int CL_SIZE  = 8,
  parameter int PF_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  l1_strm_ctrl_if.master bus
);
  localparam int SID_W = $clog2(NSTRMS);
  localparam int PTR_W = $clog2(NCL) + $clog2(CL_SIZE);
  localparam int OFS_W = $clog2(CL_SIZE);
  localparam int CNT_W = $clog2(PF_DEPTH + 1);
  localparam int AV_W  = $clog2(PF_DEPTH * CL_SIZE + 1);
  localparam int N_W   = $clog2(NPORTS + 1);
  localparam logic [CNT_W:0] PF_LIM = (CNT_W + 1)'(PF_DEPTH);

  // Per-stream state
  logic [PTR_W-1:0] rd_ptr       [NSTRMS];
  logic [PTR_W-1:0] rd_ptr_nxt   [NSTRMS];
  logic [CNT_W-1:0] lines_valid  [NSTRMS];
  logic [CNT_W-1:0] lines_nxt    [NSTRMS];
  logic [CNT_W-1:0] inflight     [NSTRMS];
  logic [CNT_W-1:0] inflight_nxt [NSTRMS];
  // Low during reset. It goes high on the first edge after release, so the
  // line requests are held off while reset is active.
  logic             run;

  // Per-port output address registers
  logic [NPORTS-1:0] out_v;
  logic [SID_W-1:0]  out_sid [NPORTS];
  logic [PTR_W-1:0]  out_ptr [NPORTS];

  logic [SID_W-1:0]  sid   [NPORTS];
  logic [N_W-1:0]    rank  [NPORTS];
  logic [NPORTS-1:0] rdy;
  logic [NPORTS-1:0] acc;
  logic [AV_W-1:0]   avail [NSTRMS];
  logic [N_W-1:0]    n_acc [NSTRMS];
  logic [NSTRMS-1:0] req_hs;
  logic [NSTRMS-1:0] rsp_hs;
  logic [NSTRMS-1:0] rst_hs;

  // Reads left in the resident lines. The current line may be partly
  // consumed, so its used offset is subtracted.
  always_comb begin
    for (int s = 0; s < NSTRMS; s++) begin
      avail[s] = '0;
      if (lines_valid[s] != '0)
        avail[s] = AV_W'(int'(lines_valid[s]) * CL_SIZE) - AV_W'(rd_ptr[s][OFS_W-1:0]);
    end
  end

  // Grants are ranked in port order. A port is granted only if every
  // lower-index port of the same stream is granted too. The addresses handed
  // out in one cycle therefore form a contiguous run in port order.
  always_comb begin
    logic chain_ok;
    chain_ok = 1'b1;
    for (int p = 0; p < NPORTS; p++)
      sid[p] = bus.i_rd_sid[p*SID_W +: SID_W];
    for (int p = 0; p < NPORTS; p++) begin
      rank[p]  = '0;
      chain_ok = 1'b1;
      for (int q = 0; q < p; q++) begin
        if (bus.i_rd_v[q] && (sid[q] == sid[p])) begin
          rank[p] = rank[p] + 1'b1;
          if (!acc[q]) chain_ok = 1'b0;
        end
      end
      rdy[p] = (!out_v[p] || bus.o_addr_r[p]) && (AV_W'(rank[p]) < avail[sid[p]])
               && !bus.i_rst_v[sid[p]] && chain_ok;
      acc[p] = rdy[p] && bus.i_rd_v[p];
    end
  end

  always_comb begin
    for (int s = 0; s < NSTRMS; s++) begin
      n_acc[s] = '0;
      for (int p = 0; p < NPORTS; p++)
        if (acc[p] && (sid[p] == SID_W'(s))) n_acc[s] = n_acc[s] + 1'b1;
    end
  end

  always_comb begin
    bus.i_rd_r   = rdy;
    bus.o_addr_v = out_v;
    for (int p = 0; p < NPORTS; p++) begin
      bus.o_addr_sid[p*SID_W +: SID_W] = out_sid[p];
      bus.o_addr_ptr[p*PTR_W +: PTR_W] = out_ptr[p];
    end
    for (int s = 0; s < NSTRMS; s++) begin
      bus.o_req_v[s] = run && !bus.i_rst_v[s] &&
                       (({1'b0, lines_valid[s]} + {1'b0, inflight[s]}) < PF_LIM);
      bus.i_rsp_r[s] = (inflight[s] != '0);
      bus.i_rst_r[s] = (inflight[s] == '0) && (n_acc[s] == '0);
    end
  end

  assign req_hs = bus.o_req_v & bus.o_req_r;
  assign rsp_hs = bus.i_rsp_v & bus.i_rsp_r;
  assign rst_hs = bus.i_rst_v & bus.i_rst_r;

  // Request, response and consumption are folded into one net update.
  // Granted reads never exceed avail, so a line is consumed only when one is
  // resident.
  always_comb begin
    logic consume;
    consume = 1'b0;
    for (int s = 0; s < NSTRMS; s++) begin
      consume         = (int'(rd_ptr[s][OFS_W-1:0]) + int'(n_acc[s])) >= CL_SIZE;
      rd_ptr_nxt[s]   = rd_ptr[s] + PTR_W'(n_acc[s]);
      lines_nxt[s]    = lines_valid[s] - CNT_W'(consume) + CNT_W'(rsp_hs[s]);
      inflight_nxt[s] = inflight[s] + CNT_W'(req_hs[s]) - CNT_W'(rsp_hs[s]);
      if (rst_hs[s]) begin
        rd_ptr_nxt[s]   = '0;
        lines_nxt[s]    = '0;
        inflight_nxt[s] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run   <= 1'b0;
      out_v <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        out_sid[p] <= '0;
        out_ptr[p] <= '0;
      end
      for (int s = 0; s < NSTRMS; s++) begin
        rd_ptr[s]      <= '0;
        lines_valid[s] <= '0;
        inflight[s]    <= '0;
      end
    end else begin
      run <= 1'b1;
      for (int p = 0; p < NPORTS; p++) begin
        if (acc[p]) begin
          out_v[p]   <= 1'b1;
          out_sid[p] <= sid[p];
          out_ptr[p] <= rd_ptr[sid[p]] + PTR_W'(rank[p]);
        end else if (bus.o_addr_r[p]) begin
          out_v[p] <= 1'b0;
        end
      end
      for (int s = 0; s < NSTRMS; s++) begin
        rd_ptr[s]      <= rd_ptr_nxt[s];
        lines_valid[s] <= lines_nxt[s];
        inflight[s]    <= inflight_nxt[s];
      end
    end
  end
endmodule

// File: tb/tb_l1_strm_ctrl.sv
// tb_l1_strm_ctrl -- directed, table-driven bench for l1_strm_ctrl using the
// default parameters (8 ports, 64 streams, 16 lines of 8, PF_DEPTH 4).
module tb_l1_strm_ctrl;
  localparam int NPORTS = 8;
  localparam int NSTRMS = 64;
  localparam int SID_W  = 6;
  localparam int PTR_W  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  l1_strm_ctrl_if #(.NPORTS(NPORTS), .NSTRMS(NSTRMS), .SID_W(SID_W), .PTR_W(PTR_W)) bus ();

  l1_strm_ctrl #(
    .NPORTS(8), .NSTRMS(64), .NCL(16), .CL_SIZE(8), .PF_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [PTR_W-1:0] ptr_of(input int p);
    return bus.o_addr_ptr[p*PTR_W +: PTR_W];
  endfunction

  function automatic logic [SID_W-1:0] sid_of(input int p);
    return bus.o_addr_sid[p*SID_W +: SID_W];
  endfunction

  task automatic set_sids(input int s);
    for (int p = 0; p < NPORTS; p++) bus.i_rd_sid[p*SID_W +: SID_W] = SID_W'(s);
  endtask

  task automatic rd_cycle(input int s, input logic [7:0] vm);
    set_sids(s);
    bus.i_rd_v = vm;
    tick();
    bus.i_rd_v = '0;
  endtask

  task automatic consume(input int s, input int k);
    for (int i = 0; i < k; i++) rd_cycle(s, 8'h01);
  endtask

  task automatic issue(input int s, input int k);
    int got = 0;
    int cyc = 0;
    bus.o_req_r[s] = 1'b1;
    while (got < k && cyc < 20) begin
      if (bus.o_req_v[s]) got++;
      tick();
      cyc++;
    end
    bus.o_req_r[s] = 1'b0;
    if (got < k) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout s=%0d: actual %0d requests required %0d", s, got, k);
    end
  endtask

  task automatic respond(input int s, input int k);
    bus.i_rsp_v[s] = 1'b1;
    for (int i = 0; i < k; i++) begin
      chk($sformatf("rsp_ready s=%0d", s), bus.i_rsp_r[s], 1'b1);
      tick();
    end
    bus.i_rsp_v[s] = 1'b0;
  endtask

  task automatic fill(input int s, input int k);
    issue(s, k);
    respond(s, k);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         sid;
    int         lines;    // lines loaded
    int         pre;      // single reads consumed before the vector
    int         pend;     // prefetches left in flight
    logic [7:0] vm;       // ports requesting sid
    logic [7:0] exp_rdy;  // expected grants
    int         base;     // expected pointer of first granted port
    logic       req_pre;  // expected o_req_v[sid] before the read
    logic       req_post; // expected o_req_v[sid] after the read
  } vec_t;

  vec_t vecs[6];

  // ---------------- test ----------------
  initial begin
    int cnt;
    int k;
    vecs[0] = '{3,  1, 0, 3, 8'hFF, 8'hFF, 0, 1'b0, 1'b1};
    vecs[1] = '{5,  1, 5, 0, 8'h66, 8'h26, 5, 1'b1, 1'b1};
    vecs[2] = '{7,  2, 0, 2, 8'hFF, 8'hFF, 0, 1'b0, 1'b1};
    vecs[3] = '{9,  1, 7, 3, 8'h81, 8'h01, 7, 1'b0, 1'b1};
    vecs[4] = '{11, 0, 0, 0, 8'h0F, 8'h00, 0, 1'b1, 1'b1};
    vecs[5] = '{13, 3, 3, 1, 8'hAA, 8'hAA, 3, 1'b0, 1'b0};

    reset        = 1'b0;
    bus.i_rd_v   = '0;
    bus.i_rd_sid = '0;
    bus.o_addr_r = '1;
    bus.o_req_r  = '0;
    bus.i_rsp_v  = '0;
    bus.i_rst_v  = '0;

    // Reset state
    #2;
    chk("reset_addr_v", bus.o_addr_v, '0);
    chk("reset_req_v", bus.o_req_v, '0);
    chk("reset_rsp_r", bus.i_rsp_r, '0);
    chk("reset_rst_r", bus.i_rst_r, {NSTRMS{1'b1}});
    #10;
    reset = 1'b1;
    tick();
    chk("req_v_first_edge", bus.o_req_v, {NSTRMS{1'b1}});

    // Cold start on stream 0
    bus.o_req_r[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_req_v[0]) cnt++;
      tick();
    end
    chk("cold_req_count", cnt, 4);
    chk("cold_req_v_full", bus.o_req_v[0], 1'b0);
    bus.o_req_r[0] = 1'b0;
    bus.i_rsp_v[0] = 1'b1;
    #1;
    chk("cold_rsp_r", bus.i_rsp_r[0], 1'b1);
    tick();
    bus.i_rsp_v[0] = 1'b0;
    #1;
    chk("cold_req_v_after_rsp", bus.o_req_v[0], 1'b0);
    set_sids(0);
    bus.i_rd_v = 8'hFF;
    #1;
    chk("cold_line_rdy", bus.i_rd_r, 8'hFF);
    tick();
    bus.i_rd_v = '0;
    #1;
    chk("cold_line_addr_v", bus.o_addr_v, 8'hFF);
    chk("cold_req_v_after_use", bus.o_req_v[0], 1'b1);

    // Table-driven single-stream vectors
    foreach (vecs[i]) begin
      fill(vecs[i].sid, vecs[i].lines);
      consume(vecs[i].sid, vecs[i].pre);
      issue(vecs[i].sid, vecs[i].pend);
      #1;
      chk($sformatf("v%0d_req_pre", i), bus.o_req_v[vecs[i].sid], vecs[i].req_pre);
      set_sids(vecs[i].sid);
      bus.i_rd_v = vecs[i].vm;
      #1;
      chk($sformatf("v%0d_rdy", i), bus.i_rd_r & vecs[i].vm, vecs[i].exp_rdy);
      tick();
      bus.i_rd_v = '0;
      #1;
      chk($sformatf("v%0d_addr_v", i), bus.o_addr_v, vecs[i].exp_rdy);
      k = 0;
      for (int p = 0; p < NPORTS; p++) begin
        if (vecs[i].exp_rdy[p]) begin
          chk($sformatf("v%0d_ptr%0d", i, p), ptr_of(p), vecs[i].base + k);
          chk($sformatf("v%0d_sid%0d", i, p), sid_of(p), vecs[i].sid);
          k++;
        end
      end
      chk($sformatf("v%0d_req_post", i), bus.o_req_v[vecs[i].sid], vecs[i].req_post);
    end

    // Stream 3 pointer continues at 8 after the fan-out
    respond(3, 1);
    rd_cycle(3, 8'h01);
    chk("fanout_next_ptr", ptr_of(0), 8);

    // Interleaved streams: ranks are counted per stream
    fill(20, 1);
    fill(21, 1);
    for (int p = 0; p < NPORTS; p++) bus.i_rd_sid[p*SID_W +: SID_W] = (p % 2 == 0) ? 6'd20 : 6'd21;
    bus.i_rd_v = 8'hFF;
    #1;
    chk("mix_rdy", bus.i_rd_r, 8'hFF);
    tick();
    bus.i_rd_v = '0;
    for (int p = 0; p < NPORTS; p++) chk($sformatf("mix_ptr%0d", p), ptr_of(p), p / 2);

    // Backpressure on port 0 stalls port 1 of the same stream
    fill(30, 1);
    bus.o_addr_r[0] = 1'b0;
    rd_cycle(30, 8'h01);
    chk("bp_addr_v0", bus.o_addr_v[0], 1'b1);
    set_sids(30);
    bus.i_rd_v = 8'h03;
    #1;
    chk("bp_stall_rdy", bus.i_rd_r[1:0], 2'b00);
    tick();
    chk("bp_hold_v", bus.o_addr_v[0], 1'b1);
    chk("bp_hold_ptr", ptr_of(0), 0);
    chk("bp_stall_rdy2", bus.i_rd_r[1:0], 2'b00);
    bus.o_addr_r[0] = 1'b1;
    #1;
    chk("bp_release_rdy", bus.i_rd_r[1:0], 2'b11);
    tick();
    bus.i_rd_v = '0;
    chk("bp_ptr0", ptr_of(0), 1);
    chk("bp_ptr1", ptr_of(1), 2);

    // Pointer wrap on stream 40
    for (int i = 0; i < 15; i++) begin
      fill(40, 1);
      rd_cycle(40, 8'hFF);
    end
    fill(40, 1);
    rd_cycle(40, 8'h3F);
    chk("wrap_ptr125", ptr_of(5), 125);
    set_sids(40);
    bus.i_rd_v = 8'h03;
    #1;
    chk("wrap_rdy", bus.i_rd_r[1:0], 2'b11);
    tick();
    bus.i_rd_v = '0;
    chk("wrap_ptr126", ptr_of(0), 126);
    chk("wrap_ptr127", ptr_of(1), 127);
    fill(40, 1);
    rd_cycle(40, 8'h01);
    chk("wrap_ptr0", ptr_of(0), 0);

    // Request and response on the same stream and cycle
    issue(60, 1);
    bus.o_req_r[60] = 1'b1;
    bus.i_rsp_v[60] = 1'b1;
    #1;
    chk("net_req_v", bus.o_req_v[60], 1'b1);
    chk("net_rsp_r", bus.i_rsp_r[60], 1'b1);
    tick();
    bus.o_req_r[60] = 1'b0;
    bus.i_rsp_v[60] = 1'b0;
    respond(60, 1);
    set_sids(60);
    bus.i_rd_v = 8'hFF;
    #1;
    chk("net_rdy_line1", bus.i_rd_r, 8'hFF);
    tick();
    chk("net_rdy_line2", bus.i_rd_r, 8'hFF);
    tick();
    bus.i_rd_v = '0;
    chk("net_ptr15", ptr_of(7), 15);

    // Stream reset with two prefetches in flight
    fill(50, 1);
    consume(50, 3);
    issue(50, 2);
    bus.i_rst_v[50] = 1'b1;
    set_sids(50);
    bus.i_rd_v = 8'h01;
    #1;
    chk("srst_req_v", bus.o_req_v[50], 1'b0);
    chk("srst_rst_r0", bus.i_rst_r[50], 1'b0);
    chk("srst_rd_blocked", bus.i_rd_r[0], 1'b0);
    bus.i_rd_v = '0;
    bus.i_rsp_v[50] = 1'b1;
    tick();
    chk("srst_rst_r1", bus.i_rst_r[50], 1'b0);
    tick();
    bus.i_rsp_v[50] = 1'b0;
    #1;
    chk("srst_rst_r_done", bus.i_rst_r[50], 1'b1);
    tick();
    bus.i_rst_v[50] = 1'b0;
    bus.i_rd_v = 8'h01;
    #1;
    chk("srst_req_resume", bus.o_req_v[50], 1'b1);
    chk("srst_lines_cleared", bus.i_rd_r[0], 1'b0);
    chk("srst_other_stream", bus.i_rsp_r[0], 1'b1);
    bus.i_rd_v = '0;
    fill(50, 1);
    rd_cycle(50, 8'h01);
    chk("srst_ptr_cleared", ptr_of(0), 0);

    // Asynchronous reset mid-cycle clears a held address at once
    fill(60, 1);
    bus.o_addr_r[2] = 1'b0;
    rd_cycle(60, 8'h04);
    chk("ares_pre_v", bus.o_addr_v[2], 1'b1);
    chk("ares_pre_ptr", ptr_of(2), 16);
    #2;
    reset = 1'b0;
    #1;
    chk("ares_addr_v", bus.o_addr_v, '0);
    chk("ares_req_v", bus.o_req_v, '0);
    chk("ares_rsp_r", bus.i_rsp_r, '0);
    chk("ares_rst_r", bus.i_rst_r, {NSTRMS{1'b1}});
    reset = 1'b1;
    bus.o_addr_r = '1;

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
